// File: rtl/keypad_in_ctrl_if.sv
// Bus-side signals of the keypad scanner: read strobe, read data and interrupt.
// The master is the bus (or testbench) and the slave is the scanner.
interface keypad_in_ctrl_if;
  logic        re;
  logic [31:0] rdata;
  logic        irq;

  modport master (output re, input rdata, input irq);
  modport slave  (input re, output rdata, output irq);
endinterface

// File: rtl/keypad_in_ctrl.sv
// 4x4 matrix keypad scanner. Column scan, frame debounce, single-key event
// detection, and a 16-bit key-code shift register with valid/overrun status.
module keypad_in_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  keypad_in_ctrl_if.slave  bus
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  DEB_MAX = 4'(DEBOUNCE);

  typedef enum logic {S_IDLE, S_HELD} state_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_q;
  logic             tick;
  logic             frame_done_q;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      prev_q, prev_d;
  logic [15:0]      deb_q, deb_d;
  logic [3:0]       stable_q, stable_d;
  state_e           state_q;
  logic [15:0]      keys_q;
  logic             valid_q;
  logic             overrun_q;
  logic             one_hot;
  logic [3:0]       code;

  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    frame_d = frame_q;
    if (tick) begin
      frame_d[{col_idx_q, 2'b00} +: 4] = ~row;
    end
  end

  // A frame that repeats the previous one extends the stable run; any change restarts it.
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    if (frame_done_q) begin
      prev_d = frame_q;
      if (frame_q == prev_q) begin
        stable_d = (stable_q >= DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
      end
      if (stable_d == DEB_MAX) begin
        deb_d = frame_q;
      end
    end
  end

  always_comb begin
    one_hot = (deb_q != 16'd0) && ((deb_q & (deb_q - 16'd1)) == 16'd0);
    code    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (deb_q[i]) code = 4'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; a later assignment
  // to the same register in the block overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      col_q        <= 4'b1110;
      frame_done_q <= 1'b0;
      frame_q      <= '0;
      prev_q       <= '0;
      deb_q        <= '0;
      stable_q     <= '0;
    end else begin
      div_q        <= div_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      deb_q        <= deb_d;
      stable_q     <= stable_d;
      frame_done_q <= tick && (col_idx_q == 2'd3);
      if (tick) begin
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= {col_q[2:0], col_q[3]};
      end
    end
  end

  // The event branch follows the read clear, so an event in a read cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      keys_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.re) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (deb_q != 16'd0) begin
            state_q <= S_HELD;
            if (one_hot) begin
              keys_q    <= {keys_q[11:0], code};
              valid_q   <= 1'b1;
              overrun_q <= ~bus.re & (overrun_q | valid_q);
            end
          end
        end
        S_HELD: begin
          if (deb_q == 16'd0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign col       = col_q;
  assign bus.rdata = {14'b0, overrun_q, valid_q, keys_q};
  assign bus.irq   = valid_q;

endmodule

// File: tb/tb_keypad_in_ctrl.sv
// Directed bench for keypad_in_ctrl: a keypad matrix model drives the rows, and
// a scoreboard queue holds the rdata expected after each key event.
module tb_keypad_in_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed;

  keypad_in_ctrl_if bus ();

  keypad_in_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[4*c+r]) row[r] = 1'b0;
        end
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] prev_keys;
  logic [31:0] exp_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: any change of the key register is an event and must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_keys = bus.rdata[15:0];
    end else if (bus.rdata[15:0] !== prev_keys) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%h required=none", bus.rdata);
      end else begin
        exp_val = exp_q.pop_front();
        check("event_rdata", bus.rdata, exp_val);
      end
      prev_keys = bus.rdata[15:0];
    end
  end

  task automatic wait_frame_start();
    logic [3:0] pc;
    bit         found;
    found = 1'b0;
    pc    = col;
    for (int i = 0; i < 8 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (col == 4'b1110 && pc == 4'b0111) found = 1'b1;
      pc = col;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_align actual=col_%b required=frame_start", col);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] mask, input int hold, input int rel);
    wait_frame_start();
    pressed = mask;
    wait_frames(hold);
    pressed = '0;
    wait_frames(rel);
  endtask

  task automatic read_pulse();
    @(posedge clk); #1;
    bus.re = 1'b1;
    @(posedge clk); #1;
    bus.re = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.re  = 1'b0;
    pressed = '0;

    // Reset state and first column step.
    repeat (3) @(posedge clk);
    #1;
    check("reset_col", {28'd0, col}, 32'h0000_000E);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", {31'd0, bus.irq}, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("col_hold", {28'd0, col}, 32'h0000_000E);
    @(posedge clk); #1;
    check("col_step", {28'd0, col}, 32'h0000_000D);

    // Single key 9 (c=2, r=1), then a read clears valid but keeps keys.
    exp_q.push_back(32'h0001_0009);
    press(16'h0200, 3, 3);
    check("irq_after_key9", {31'd0, bus.irq}, 32'h1);
    read_pulse();
    check("read_clears_valid", bus.rdata, 32'h0000_0009);

    // Sequence 1, A, 3, F with no reads; overrun from the second key onwards.
    exp_q.push_back(32'h0001_0091);
    press(16'h0002, 3, 3);
    exp_q.push_back(32'h0003_091A);
    press(16'h0400, 3, 3);
    exp_q.push_back(32'h0003_91A3);
    press(16'h0008, 3, 3);
    exp_q.push_back(32'h0003_1A3F);
    press(16'h8000, 3, 3);
    check("sequence_rdata", bus.rdata, 32'h0003_1A3F);

    // Bounce: key 0 in alternating frames yields nothing, then a steady hold yields code 0.
    wait_frame_start();
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      wait_frames(1);
    end
    check("bounce_no_event", bus.rdata, 32'h0003_1A3F);
    exp_q.push_back(32'h0003_A3F0);
    pressed = 16'h0001;
    wait_frames(3);
    pressed = '0;
    wait_frames(3);
    read_pulse();

    // Chord 5+6, then 5 alone while held: no events. After full release, 5 emits.
    wait_frame_start();
    pressed = 16'h0060;
    wait_frames(3);
    pressed = 16'h0020;
    wait_frames(3);
    pressed = '0;
    wait_frames(3);
    check("chord_no_event", bus.rdata, 32'h0000_A3F0);
    exp_q.push_back(32'h0001_3F05);
    press(16'h0020, 3, 3);

    // Key C sets overrun; key 7 then arrives in the same cycle as a read.
    exp_q.push_back(32'h0003_F05C);
    press(16'h1000, 3, 3);
    exp_q.push_back(32'h0001_05C7);
    wait_frame_start();
    pressed = 16'h0080;
    repeat (33) @(posedge clk);
    #1;
    check("collision_pre_status", {30'd0, bus.rdata[17:16]}, 32'h3);
    bus.re = 1'b1;
    @(posedge clk); #1;
    bus.re = 1'b0;
    check("collision_post", bus.rdata, 32'h0001_05C7);
    wait_frames(1);
    pressed = '0;
    wait_frames(3);
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset mid-scan discards everything; scanning restarts at column 0.
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midscan_reset_col", {28'd0, col}, 32'h0000_000E);
    check("midscan_reset_rdata", bus.rdata, 32'h0);
    check("midscan_reset_irq", {31'd0, bus.irq}, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("restart_col_hold", {28'd0, col}, 32'h0000_000E);
    @(posedge clk); #1;
    check("restart_col_step", {28'd0, col}, 32'h0000_000D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
